sobel_edge_core: RTL and testbench

- Streaming 3x3 Sobel edge detector with an APB configuration/status slave.
- Accepts 8-bit grayscale pixels in raster order, one per `valid_in` cycle.
- Computes a gradient magnitude for every interior pixel and emits a thresholded binary edge pixel; `sobel_done` flags frame completion.
- Sits between an APB host and a pixel streaming source/sink.

---
 rtl/sobel_pkg.sv | 44 ++++
 rtl/sobel_window.sv | 67 ++++++
 rtl/sobel_edge_core.sv | 230 +++++++++++++++++++++++
 tb/tb_sobel_edge_core.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types, register map and gradient helper for the Sobel edge core.
// The optional raw-magnitude output mode is enabled with SOBEL_RAW_MAG_EN.
package sobel_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned COEF_W = 4;
  localparam int unsigned GRAD_W = 16;
  localparam int unsigned DIM_W  = 16;
  localparam int unsigned APB_W  = 32;

  localparam logic [7:0] ADDR_THRESH = 8'h00;
  localparam logic [7:0] ADDR_WIDTH  = 8'h04;
  localparam logic [7:0] ADDR_HEIGHT = 8'h08;
  localparam logic [7:0] ADDR_TOTAL  = 8'h0C;
  localparam logic [7:0] ADDR_K1     = 8'h10;
  localparam logic [7:0] ADDR_K2     = 8'h14;
  localparam logic [7:0] ADDR_K3     = 8'h18;
  localparam logic [7:0] ADDR_K4     = 8'h1C;
  localparam logic [7:0] ADDR_CTRL   = 8'h20;
  localparam logic [7:0] ADDR_STATUS = 8'h24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [2:0][2:0] win_t;

  // One coefficient-weighted pixel difference, k*(a-b), in signed gradient precision.
  function automatic logic signed [GRAD_W-1:0] grad_term(
    input logic signed [COEF_W-1:0] k,
    input pix_t                     a,
    input pix_t                     b
  );
    logic signed [GRAD_W-1:0] w_diff;
    logic signed [GRAD_W-1:0] w_coef;
    w_diff = $signed(GRAD_W'(a)) - $signed(GRAD_W'(b));
    w_coef = $signed(GRAD_W'(k));
    return w_coef * w_diff;
  endfunction

endpackage

// File: rtl/sobel_window.sv
// Two line buffers feeding a 3x3 sliding window; tracks the raster position of
// the incoming pixel and strobes o_win_valid when the window covers a full neighbourhood.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic [DIM_W-1:0] i_width,
  input  logic             i_accept,
  input  pix_t             i_pixel,
  output win_t             o_win,
  output logic             o_win_valid
);

  localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  pix_t             r_lb0 [MAX_WIDTH];
  pix_t             r_lb1 [MAX_WIDTH];
  logic [DIM_W-1:0] r_col;
  logic [DIM_W-1:0] r_row;
  win_t             r_win;
  logic             r_win_valid;
  logic [AW-1:0]    w_idx;

  assign w_idx = r_col[AW-1:0];

  // lb0 holds the previous row, lb1 the row before it, both indexed by column.
  always_ff @(posedge clk) begin
    if (i_accept) begin
      r_lb1[w_idx] <= r_lb0[w_idx];
      r_lb0[w_idx] <= i_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win       <= '0;
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= i_accept && (r_row >= DIM_W'(2)) && (r_col >= DIM_W'(2));
      if (i_accept) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb1[w_idx];
        r_win[1][2] <= r_lb0[w_idx];
        r_win[2][2] <= i_pixel;
        if (r_col == i_width - DIM_W'(1)) begin
          r_col <= '0;
          r_row <= r_row + DIM_W'(1);
        end else begin
          r_col <= r_col + DIM_W'(1);
        end
      end
    end
  end

  assign o_win       = r_win;
  assign o_win_valid = r_win_valid;

endmodule

// File: rtl/sobel_edge_core.sv
// Streaming 3x3 Sobel edge detector with APB config/status registers.
// Define SOBEL_RAW_MAG_EN to add CTRL.mode selecting raw thresholded magnitude output.
module sobel_edge_core
  import sobel_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 1024,
  parameter int unsigned PIX_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             valid_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic             valid_out,
  output logic             sobel_done
);

  logic [7:0]        r_thresh;
  logic [DIM_W-1:0]  r_width;
  logic [DIM_W-1:0]  r_height;
  logic [31:0]       r_total;
  logic [COEF_W-1:0] r_k1;
  logic [COEF_W-1:0] r_k2;
  logic [COEF_W-1:0] r_k3;
  logic [COEF_W-1:0] r_k4;
  state_t            r_state;
  logic              r_done;
  logic              r_cfg_err;
  logic [31:0]       r_pix_cnt;
  logic              r_last;
  pix_t              r_pix_out;
  logic              r_valid_out;

  logic              w_busy;
  logic              w_mode;
  logic [7:0]        w_addr;
  logic              w_access;
  logic              w_mapped;
  logic              w_cfg_addr;
  logic [APB_W-1:0]  w_rdata;
  logic              w_err;
  logic              w_cfg_we;
  logic              w_start;
  logic              w_cfg_ok;
  logic              w_start_ok;
  logic              w_accept;
  win_t              w_win;
  logic              w_win_valid;
  logic signed [GRAD_W-1:0] w_gx;
  logic signed [GRAD_W-1:0] w_gy;
  logic [GRAD_W-1:0] w_ax;
  logic [GRAD_W-1:0] w_ay;
  logic [GRAD_W-1:0] w_sum;
  pix_t              w_mag;
  pix_t              w_edge_pix;
  logic              w_unused;

  assign w_busy   = (r_state == ST_RUN);
  assign w_addr   = PADDR[7:0];
  assign w_access = PSEL & PENABLE;
  assign w_unused = ^PADDR[31:8];

`ifdef SOBEL_RAW_MAG_EN
  logic r_mode;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= 1'b0;
    end else if (w_access && PWRITE && (w_addr == ADDR_CTRL)) begin
      r_mode <= PWDATA[1];
    end
  end
  assign w_mode = r_mode;
`else
  assign w_mode = 1'b0;
`endif

  // Read mux and address decode.
  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    case (w_addr)
      ADDR_THRESH: w_rdata = APB_W'(r_thresh);
      ADDR_WIDTH:  w_rdata = APB_W'(r_width);
      ADDR_HEIGHT: w_rdata = APB_W'(r_height);
      ADDR_TOTAL:  w_rdata = r_total;
      ADDR_K1:     w_rdata = APB_W'(r_k1);
      ADDR_K2:     w_rdata = APB_W'(r_k2);
      ADDR_K3:     w_rdata = APB_W'(r_k3);
      ADDR_K4:     w_rdata = APB_W'(r_k4);
      ADDR_CTRL:   w_rdata = {30'd0, w_mode, 1'b0};
      ADDR_STATUS: w_rdata = {29'd0, r_cfg_err, r_done, w_busy};
      default:     w_mapped = 1'b0;
    endcase
  end

  assign w_cfg_addr = w_mapped && (w_addr <= ADDR_K4);
  assign w_err      = w_access && (!w_mapped
                                   || (PWRITE && (w_addr == ADDR_STATUS))
                                   || (PWRITE && w_cfg_addr && w_busy));
  assign w_cfg_we   = w_access && PWRITE && w_cfg_addr && !w_busy;
  assign w_start    = w_access && PWRITE && (w_addr == ADDR_CTRL) && PWDATA[0];

  assign PRDATA  = (PSEL && !reset) ? w_rdata : '0;
  assign PSLVERR = w_err && !reset;
  assign PREADY  = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_thresh <= 8'h80;
      r_width  <= '0;
      r_height <= '0;
      r_total  <= '0;
      r_k1     <= COEF_W'(1);
      r_k2     <= COEF_W'(2);
      r_k3     <= COEF_W'(1);
      r_k4     <= COEF_W'(2);
    end else if (w_cfg_we) begin
      case (w_addr)
        ADDR_THRESH: r_thresh <= PWDATA[7:0];
        ADDR_WIDTH:  r_width  <= PWDATA[DIM_W-1:0];
        ADDR_HEIGHT: r_height <= PWDATA[DIM_W-1:0];
        ADDR_TOTAL:  r_total  <= PWDATA;
        ADDR_K1:     r_k1     <= PWDATA[COEF_W-1:0];
        ADDR_K2:     r_k2     <= PWDATA[COEF_W-1:0];
        ADDR_K3:     r_k3     <= PWDATA[COEF_W-1:0];
        ADDR_K4:     r_k4     <= PWDATA[COEF_W-1:0];
        default: ;
      endcase
    end
  end

  assign w_cfg_ok = (r_width >= DIM_W'(3))
                 && (32'(r_width) <= 32'(MAX_WIDTH))
                 && (r_height >= DIM_W'(3))
                 && (r_total == 32'(r_width) * 32'(r_height));
  assign w_start_ok = w_start && !w_busy && w_cfg_ok;
  assign w_accept   = valid_in && w_busy && !r_last;

  // Frame control: DONE is entered once the last pixel is in and the pipeline is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_pix_cnt <= '0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            if (w_cfg_ok) begin
              r_state   <= ST_RUN;
              r_cfg_err <= 1'b0;
              r_done    <= 1'b0;
              r_pix_cnt <= '0;
              r_last    <= 1'b0;
            end else begin
              r_state   <= ST_IDLE;
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_pix_cnt <= r_pix_cnt + 32'd1;
            if (r_pix_cnt == r_total - 32'd1) r_last <= 1'b1;
          end
          if (r_last && !w_win_valid && !r_valid_out) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sobel_window #(
    .MAX_WIDTH (MAX_WIDTH)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_start_ok),
    .i_width     (r_width),
    .i_accept    (w_accept),
    .i_pixel     (pixel_in),
    .o_win       (w_win),
    .o_win_valid (w_win_valid)
  );

  // Gradients: Gx is right column minus left, Gy is bottom row minus top.
  assign w_gx = grad_term(r_k1, w_win[0][2], w_win[0][0])
              + grad_term(r_k2, w_win[1][2], w_win[1][0])
              + grad_term(r_k1, w_win[2][2], w_win[2][0]);
  assign w_gy = grad_term(r_k3, w_win[2][0], w_win[0][0])
              + grad_term(r_k4, w_win[2][1], w_win[0][1])
              + grad_term(r_k3, w_win[2][2], w_win[0][2]);
  assign w_ax  = w_gx[GRAD_W-1] ? GRAD_W'(-w_gx) : GRAD_W'(w_gx);
  assign w_ay  = w_gy[GRAD_W-1] ? GRAD_W'(-w_gy) : GRAD_W'(w_gy);
  assign w_sum = w_ax + w_ay;
  assign w_mag = (w_sum > GRAD_W'(255)) ? 8'hFF : w_sum[7:0];

  always_comb begin
    w_edge_pix = '0;
    if (w_mag >= r_thresh) w_edge_pix = w_mode ? w_mag : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_out <= 1'b0;
      r_pix_out   <= '0;
    end else begin
      r_valid_out <= w_win_valid;
      if (w_win_valid) r_pix_out <= w_edge_pix;
    end
  end

  assign pixel_out  = r_pix_out;
  assign valid_out  = r_valid_out;
  assign sobel_done = r_done;

endmodule

// File: tb/tb_sobel_edge_core.sv
// Self-checking bench for sobel_edge_core: APB register table, frame-level
// reference model with randomized images/coefficients, and control corner cases.
module tb_sobel_edge_core;

  localparam int unsigned MAXW = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  pixel_in = '0;
  logic        valid_in = 1'b0;
  logic [7:0]  pixel_out;
  logic        valid_out, sobel_done;

  always #5 clk = ~clk;

  sobel_edge_core #(.MAX_WIDTH(MAXW), .PIX_W(8)) dut (
    .clk(clk), .reset(reset),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .pixel_in(pixel_in), .valid_in(valid_in),
    .pixel_out(pixel_out), .valid_out(valid_out), .sobel_done(sobel_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference image and configuration for the current frame.
  int img[$];
  int cw, ch, ck1, ck2, ck3, ck4, cthr, cmode;
  int exp_val[$];
  int exp_cyc[$];
  int n_out, n_hi, hi_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: every valid_out must match the next expected value and cycle.
  always @(negedge clk) begin
    int v, c;
    if (valid_out) begin
      n_out++;
      if (int'(pixel_out) == hi_val) n_hi++;
      n_tests++;
      if (exp_cyc.size() == 0 || exp_val.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got pixel %0d at cycle %0d, required no output", pixel_out, cyc);
      end else begin
        v = exp_val.pop_front();
        c = exp_cyc.pop_front();
        if (int'(pixel_out) != v || cyc != c) begin
          n_fail++;
          $display("FAIL edge_pixel: got %0d at cycle %0d, required %0d at cycle %0d", pixel_out, cyc, v, c);
        end
      end
    end
  end

  function automatic int px(input int r, input int c);
    return img[r * cw + c];
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int model_pix(input int r, input int c);
    int gx, gy, mag;
    gx = ck1 * (px(r-1, c+1) - px(r-1, c-1)) + ck2 * (px(r, c+1) - px(r, c-1))
       + ck1 * (px(r+1, c+1) - px(r+1, c-1));
    gy = ck3 * (px(r+1, c-1) - px(r-1, c-1)) + ck4 * (px(r+1, c) - px(r-1, c))
       + ck3 * (px(r+1, c+1) - px(r-1, c+1));
    mag = iabs(gx) + iabs(gy);
    if (mag > 255) mag = 255;
    if (mag < cthr) return 0;
    return (cmode != 0) ? mag : 255;
  endfunction

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    rd = PRDATA; err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd; logic err;
    apb(1'b1, addr, data, rd, err);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic err;
    apb(1'b0, addr, 32'h0, rd, err);
    chk(name, rd, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_val.delete(); exp_cyc.delete();
  endtask

  task automatic configure(input int w, input int h, input int total,
                           input int k1, input int k2, input int k3, input int k4, input int thr);
    wr(32'h00, 32'(thr)); wr(32'h04, 32'(w)); wr(32'h08, 32'(h)); wr(32'h0C, 32'(total));
    wr(32'h10, 32'(k1 & 15)); wr(32'h14, 32'(k2 & 15));
    wr(32'h18, 32'(k3 & 15)); wr(32'h1C, 32'(k4 & 15));
  endtask

  // kind 0: uniform a, 1: vertical step a|b at column 5, 2: random
  task automatic fill(input int kind, input int w, input int h, input int a, input int b);
    img.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        img.push_back(kind == 0 ? a : kind == 1 ? (c < 5 ? a : b) : int'($urandom_range(0, 255)));
  endtask

  task automatic feed(input int n, input int gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps != 0 && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        valid_in = 1'b0; pixel_in = 8'($urandom);
      end
      @(posedge clk); #1;
      valid_in = 1'b1; pixel_in = 8'(img[i]);
      if (i / cw >= 2 && i % cw >= 2) exp_cyc.push_back(cyc + 2);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic feed_junk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1; pixel_in = 8'($urandom);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic setup_frame(input int w, input int h, input int k1, input int k2,
                             input int k3, input int k4, input int thr, input int mode);
    cw = w; ch = h; ck1 = k1; ck2 = k2; ck3 = k3; ck4 = k4; cthr = thr;
`ifdef SOBEL_RAW_MAG_EN
    cmode = mode;
`else
    cmode = 0;
`endif
    exp_val.delete(); exp_cyc.delete();
    for (int r = 1; r <= h - 2; r++)
      for (int c = 1; c <= w - 2; c++)
        exp_val.push_back(model_pix(r, c));
    configure(w, h, w * h, k1, k2, k3, k4, thr);
    wr(32'h20, 32'(1 | (mode << 1)));
    n_out = 0; n_hi = 0;
  endtask

  task automatic run_frame(input string name, input int w, input int h, input int k1, input int k2,
                           input int k3, input int k4, input int thr, input int mode, input int gaps);
    setup_frame(w, h, k1, k2, k3, k4, thr, mode);
    rd_chk({name, "_status_busy"}, 32'h24, 32'h1);
    feed(w * h, gaps);
    for (int k = 0; k < 200 && !sobel_done; k++) @(negedge clk);
    chk({name, "_done"}, 32'(sobel_done), 32'h1);
    chk({name, "_out_count"}, 32'(n_out), 32'((w - 2) * (h - 2)));
    chk({name, "_missing"}, 32'(exp_val.size()), 32'h0);
    rd_chk({name, "_status_done"}, 32'h24, 32'h2);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        chk_rd;
  } apb_vec_t;

  apb_vec_t vecs[18];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w, h;

    vecs = '{
      '{1'b0, 32'h00, 32'h0,    32'h80, 1'b0, 1'b1},
      '{1'b0, 32'h04, 32'h0,    32'h0,  1'b0, 1'b1},
      '{1'b0, 32'h08, 32'h0,    32'h0,  1'b0, 1'b1},
      '{1'b0, 32'h0C, 32'h0,    32'h0,  1'b0, 1'b1},
      '{1'b0, 32'h10, 32'h0,    32'h1,  1'b0, 1'b1},
      '{1'b0, 32'h14, 32'h0,    32'h2,  1'b0, 1'b1},
      '{1'b0, 32'h18, 32'h0,    32'h1,  1'b0, 1'b1},
      '{1'b0, 32'h1C, 32'h0,    32'h2,  1'b0, 1'b1},
      '{1'b0, 32'h20, 32'h0,    32'h0,  1'b0, 1'b1},
      '{1'b0, 32'h24, 32'h0,    32'h0,  1'b0, 1'b1},
      '{1'b0, 32'h40, 32'h0,    32'h0,  1'b1, 1'b1},
      '{1'b1, 32'h24, 32'h7,    32'h0,  1'b1, 1'b0},
      '{1'b0, 32'h24, 32'h0,    32'h0,  1'b0, 1'b1},
      '{1'b1, 32'h00, 32'h1234, 32'h0,  1'b0, 1'b0},
      '{1'b0, 32'h00, 32'h0,    32'h34, 1'b0, 1'b1},
      '{1'b1, 32'h44, 32'h5,    32'h0,  1'b1, 1'b0},
      '{1'b0, 32'h02, 32'h0,    32'h0,  1'b1, 1'b1},
      '{1'b0, 32'h28, 32'h0,    32'h0,  1'b1, 1'b1}
    };
    hi_val = 255;
    n_out = 0; n_hi = 0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_sobel_done", 32'(sobel_done), 32'h0);
    chk("rst_pixel_out", 32'(pixel_out), 32'h0);
    chk("rst_prdata_idle", PRDATA, 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    chk("pready", 32'(PREADY), 32'h1);

    for (int i = 0; i < 18; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
      chk($sformatf("apb%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rd) chk($sformatf("apb%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Pixels presented in IDLE are dropped.
    feed_junk(6);

    fill(0, 10, 10, 50, 0);
    run_frame("uniform", 10, 10, 1, 2, 1, 2, 100, 0, 0);
    chk("uniform_edges", 32'(n_hi), 32'h0);

    fill(1, 10, 10, 0, 200);
    run_frame("step", 10, 10, 1, 2, 1, 2, 100, 0, 1);
    chk("step_edges", 32'(n_hi), 32'd16);

    // Pixels presented in DONE are dropped and done stays asserted.
    feed_junk(5);
    chk("done_hold", 32'(sobel_done), 32'h1);

    fill(2, 3, 3, 0, 0);
    run_frame("min3x3", 3, 3, 1, 2, 1, 2, 40, 0, 0);
    for (int t = 0; t < 4; t++) begin
      w = $urandom_range(3, 12);
      h = $urandom_range(3, 8);
      fill(2, w, h, 0, 0);
      run_frame($sformatf("rand%0d", t), w, h, $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8,
                $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8, $urandom_range(0, 255), 0, 1);
    end
    fill(2, MAXW, 3, 0, 0);
    run_frame("maxwidth", MAXW, 3, 1, 2, 1, 2, 128, 0, 0);

    // Invalid configurations are rejected with cfg_err.
    do_reset();
    configure(10, 10, 99, 1, 2, 1, 2, 100);
    wr(32'h20, 32'h1);
    rd_chk("bad_total_status", 32'h24, 32'h4);
    chk("bad_total_done", 32'(sobel_done), 32'h0);
    feed_junk(8);
    configure(2, 3, 6, 1, 2, 1, 2, 100);
    wr(32'h20, 32'h1);
    rd_chk("bad_width_status", 32'h24, 32'h4);
    configure(MAXW + 1, 3, (MAXW + 1) * 3, 1, 2, 1, 2, 100);
    wr(32'h20, 32'h1);
    rd_chk("over_width_status", 32'h24, 32'h4);
    configure(10, 2, 20, 1, 2, 1, 2, 100);
    wr(32'h20, 32'h1);
    rd_chk("bad_height_status", 32'h24, 32'h4);

    // Config write while busy, then reset mid-frame.
    fill(2, 10, 10, 0, 0);
    setup_frame(10, 10, 1, 2, 1, 2, 60, 0);
    feed(30, 0);
    apb(1'b1, 32'h00, 32'h11, rd, err);
    chk("busy_write_err", 32'(err), 32'h1);
    rd_chk("busy_thresh_kept", 32'h00, 32'd60);
    chk("partial_outputs", 32'(n_out), 32'd8);
    do_reset();
    @(negedge clk);
    chk("abort_valid_out", 32'(valid_out), 32'h0);
    chk("abort_done", 32'(sobel_done), 32'h0);
    rd_chk("abort_status", 32'h24, 32'h0);
    rd_chk("abort_thresh", 32'h00, 32'h80);

    fill(2, 7, 5, 0, 0);
    run_frame("after_abort", 7, 5, -1, 3, 2, -2, 30, 0, 1);

`ifdef SOBEL_RAW_MAG_EN
    hi_val = 40;
    fill(1, 10, 10, 0, 10);
    run_frame("raw_step", 10, 10, 1, 2, 1, 2, 0, 1, 0);
    chk("raw_edges", 32'(n_hi), 32'd16);
    rd_chk("raw_mode_read", 32'h20, 32'h2);
    fill(2, 9, 6, 0, 0);
    run_frame("raw_rand", 9, 6, 2, -3, 1, 4, 50, 1, 1);
`else
    wr(32'h20, 32'h2);
    rd_chk("mode_ignored", 32'h20, 32'h0);
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
